up_dn_counter_seq: RTL and testbench
====================================

# up_dn_counter_seq

Command-driven sequencer for the 5-bit saturating up/down counter. It accepts one command at a time over a valid/ready handshake and drives the counter's `IN`, `Load`, `Up` and `Down` inputs. It uses the counter's `Counter`, `Low` and `High` outputs as feedback to run loads, seek-to-target moves, full-range bounce sweeps and timed holds. It sits between a host/control FSM and the counter, and is the only driver of the counter's control inputs.

## Interface
- `WIDTH`, 5, counter width; `MAX` = 2^WIDTH-1 = 31.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `Cmd_Valid` in 1: command present.
- `Cmd_Ready` out 1: sequencer can accept a command.
- `Cmd_Op` in 2: opcode. 00 LOAD, 01 SEEK, 10 BOUNCE, 11 HOLD.
- `Cmd_Arg` in WIDTH: value, target, sweep count or hold cycles, depending on opcode.
- `Abort` in 1: cancel the current command.
- `Counter` in WIDTH: counter value feedback.
- `Low` in 1: counter == 0.
- `High` in 1: counter == MAX.
- `IN` out WIDTH: load value to the counter.
- `Load` out 1: counter load.
- `Up` out 1: counter increment.
- `Down` out 1: counter decrement.
- `Busy` out 1: command in progress.
- `Done` out 1: one-cycle pulse at completion.

## Operation
- Counter contract:
  - Load has priority over Down, and Down over Up.
  - The counter updates on the `CLK` edge that samples the controls.
  - The counter saturates at 0 and MAX.
- States: IDLE, LOAD, SEEK, BNC_DN, BNC_UP, HOLD, DONE.
- IDLE:
  - `Cmd_Ready`=1. All other outputs are 0.
  - `Cmd_Valid`&`Cmd_Ready` at an edge latches op/arg into `op_r`/`arg_r` and enters the op state.
- LOAD:
  - `Load`=1 and `IN`=`arg_r` for exactly one cycle, then DONE.
- SEEK:
  - `Up`=(`Counter`<`arg_r`) and `Down`=(`Counter`>`arg_r`), both combinational from the current `Counter`.
  - When `Counter`==`arg_r`, controls are 0 and the next state is DONE. There is never an overshoot.
- BOUNCE:
  - If `arg_r`==0, go to DONE immediately.
  - Otherwise load `rem`=`arg_r` and enter BNC_DN.
  - BNC_DN: `Down`=!`Low`. When `Low`=1, go to BNC_UP.
  - BNC_UP: `Up`=!`High`. When `High`=1, decrement `rem`. If the new `rem` is 0, go to DONE; otherwise go to BNC_DN.
- HOLD:
  - `Load`=`Up`=`Down`=0 for `arg_r` cycles, then DONE. `arg_r`=0 means one HOLD cycle.
- DONE:
  - `Done`=1 for one cycle, then IDLE.
- `Busy`=1 in every state except IDLE.
- `Abort`=1 in any non-IDLE state:
  - Forces `Load`/`Up`/`Down` to 0 in that same cycle.
  - Next state is IDLE, with no `Done`.
  - `Abort` is ignored in IDLE.
- `Load`, `Up` and `Down` are never asserted together, except that Load is only asserted alone.

## Timing
- Reset values: state IDLE, `Cmd_Ready`=1, `IN`=0, `Load`=`Up`=`Down`=0, `Busy`=0, `Done`=0, `rem`=0.
- Reset mid-command drops all controls immediately, asynchronously.
- `Cmd_Ready` is a function of state only. It has no combinational path from `Cmd_Valid`.
- A new command may be accepted on the edge that leaves DONE. The gap between back-to-back commands is at least 1 cycle (the DONE cycle).
- Latency, counted in cycles from the acceptance edge to the rising edge of `Done`:
  - LOAD: 2.
  - SEEK: |`Counter`−`arg_r`|+2.
  - HOLD(n): max(n,1)+1.
  - BOUNCE(n) from value v: v + n·MAX + (n−1)·MAX + 2·n + 1.
  - For BOUNCE, the bench checks the value computed from this rule.
- `IN` is registered and holds the last loaded value outside LOAD.
- Out-of-contract feedback is not an error:
  - If `Counter` changes externally during SEEK, the direction is re-evaluated every cycle.

## Structure
- Shared package `up_dn_seq_pkg` holds:
  - The opcode constants (OP_LOAD, OP_SEEK, OP_BOUNCE, OP_HOLD).
  - The state enumeration.
  - `WIDTH`/`MAX`.
- Internally the sequencer has no sub-module: one state register, `op_r`/`arg_r`, `rem` and a hold cycle counter.
- One integration module, `up_dn_counter_sys`, instantiates `up_dn_counter_seq` plus the existing counter. The bench targets it.

## Test plan
- Reset, then LOAD 15 -> `Load`=1 for 1 cycle with `IN`=15. `Counter`=15. `Done` 2 cycles after acceptance.
- From 15, SEEK 3 -> `Down` for 12 cycles, `Counter`=3, no overshoot, `Done` at acceptance+14. Then SEEK 3 again -> `Done` at +2 with no `Up`/`Down`.
- From 3, BOUNCE 2 -> `Counter` reaches 0 (`Low`), then 31 (`High`), then 0, then 31. `Done` once, exactly at the computed latency. `Counter`=31 at completion.
- HOLD 5 with `Cmd_Valid` held high -> controls are 0 for 5 cycles. The second command is accepted only after `Done`, and `Cmd_Ready`=0 throughout.
- Abort in the middle of SEEK 31 from 0 (at `Counter`=10) -> `Up` drops in the same cycle, `Counter` stays 10, IDLE next cycle, no `Done`.
- `RST` low asynchronously during BOUNCE -> all outputs reach their reset values without waiting for a clock edge. After `RST` rises, `Cmd_Ready`=1 and LOAD 7 works normally.

Source files
------------

// File: rtl/up_dn_seq_pkg.sv
// Shared definitions for the up/down counter sequencer: width, opcodes, FSM states.
package up_dn_seq_pkg;

  localparam int WIDTH = 5;
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SEEK   = 2'b01,
    OP_BOUNCE = 2'b10,
    OP_HOLD   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEEK,
    ST_BNC_DN,
    ST_BNC_UP,
    ST_HOLD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/up_dn_counter.sv
// 5-bit saturating up/down counter; Load beats Down, Down beats Up.
module up_dn_counter
  import up_dn_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic             Load,
  input  logic             Up,
  input  logic             Down,
  output logic [WIDTH-1:0] Counter,
  output logic             Low,
  output logic             High
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Counter <= '0;
    end else if (Load) begin
      Counter <= IN;
    end else if (Down) begin
      if (Counter != '0) Counter <= Counter - 1'b1;
    end else if (Up) begin
      if (Counter != MAX) Counter <= Counter + 1'b1;
    end
  end

  assign Low  = (Counter == '0);
  assign High = (Counter == MAX);

endmodule

// File: rtl/up_dn_counter_sys.sv
// Integration wrapper: sequencer driving the saturating up/down counter.
module up_dn_counter_sys
  import up_dn_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [1:0]       Cmd_Op,
  input  logic [WIDTH-1:0] Cmd_Arg,
  input  logic             Abort,
  output logic [WIDTH-1:0] Counter,
  output logic             Busy,
  output logic             Done
);

  logic [WIDTH-1:0] in_val;
  logic             load, up, down, low, high;

  up_dn_counter_seq u_seq (
    .CLK       (CLK),
    .RST       (RST),
    .Cmd_Valid (Cmd_Valid),
    .Cmd_Ready (Cmd_Ready),
    .Cmd_Op    (Cmd_Op),
    .Cmd_Arg   (Cmd_Arg),
    .Abort     (Abort),
    .Counter   (Counter),
    .Low       (low),
    .High      (high),
    .IN        (in_val),
    .Load      (load),
    .Up        (up),
    .Down      (down),
    .Busy      (Busy),
    .Done      (Done)
  );

  up_dn_counter u_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .IN      (in_val),
    .Load    (load),
    .Up      (up),
    .Down    (down),
    .Counter (Counter),
    .Low     (low),
    .High    (high)
  );

endmodule

// File: rtl/up_dn_counter_seq.sv
// Command-driven sequencer: runs LOAD / SEEK / BOUNCE / HOLD on the saturating counter.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a command, Cmd_Ready=1
// ST_LOAD   | one-cycle Load pulse with IN=arg_r
// ST_SEEK   | step towards arg_r until Counter==arg_r
// ST_BNC_DN | sweep down until Low
// ST_BNC_UP | sweep up until High, then count one bounce off rem
// ST_HOLD   | controls idle for max(arg_r,1) cycles
// ST_DONE   | one-cycle Done pulse, may accept the next command
module up_dn_counter_seq
  import up_dn_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [1:0]       Cmd_Op,
  input  logic [WIDTH-1:0] Cmd_Arg,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Counter,
  input  logic             Low,
  input  logic             High,
  output logic [WIDTH-1:0] IN,
  output logic             Load,
  output logic             Up,
  output logic             Down,
  output logic             Busy,
  output logic             Done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state, state_nxt;
  op_e              op_r;
  logic [WIDTH-1:0] arg_r;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] hold_cnt;
  logic [WIDTH-1:0] in_r;
  logic             accept;
  logic             abort_act;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      op_r     <= OP_LOAD;
      arg_r    <= '0;
      rem      <= '0;
      hold_cnt <= '0;
      in_r     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_r     <= op_e'(Cmd_Op);
        arg_r    <= Cmd_Arg;
        rem      <= Cmd_Arg;
        hold_cnt <= (Cmd_Arg == '0) ? ONE : Cmd_Arg;
        if (op_e'(Cmd_Op) == OP_LOAD) in_r <= Cmd_Arg;
      end else if (!abort_act) begin
        if (state == ST_BNC_UP && High) rem <= rem - 1'b1;
        if (state == ST_HOLD) hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  assign IN        = in_r;
  assign abort_act = Abort && (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    Cmd_Ready = 1'b0;
    Load      = 1'b0;
    Up        = 1'b0;
    Down      = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    accept    = 1'b0;

    case (state)
      ST_IDLE: begin
        Busy      = 1'b0;
        Cmd_Ready = 1'b1;
        accept    = Cmd_Valid;
      end
      ST_LOAD: begin
        Load      = (op_r == OP_LOAD);
        state_nxt = ST_DONE;
      end
      ST_SEEK: begin
        Up   = (Counter < arg_r);
        Down = (Counter > arg_r);
        if (Counter == arg_r) state_nxt = ST_DONE;
      end
      ST_BNC_DN: begin
        Down = !Low;
        if (Low) state_nxt = ST_BNC_UP;
      end
      ST_BNC_UP: begin
        Up = !High;
        if (High) state_nxt = (rem == ONE) ? ST_DONE : ST_BNC_DN;
      end
      ST_HOLD: begin
        if (hold_cnt == ONE) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        Done      = 1'b1;
        Cmd_Ready = 1'b1;
        accept    = Cmd_Valid;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Abort wins over everything, including a command offered during DONE.
    if (abort_act) begin
      Load      = 1'b0;
      Up        = 1'b0;
      Down      = 1'b0;
      Done      = 1'b0;
      accept    = 1'b0;
      state_nxt = ST_IDLE;
    end else if (accept) begin
      case (op_e'(Cmd_Op))
        OP_LOAD:   state_nxt = ST_LOAD;
        OP_SEEK:   state_nxt = ST_SEEK;
        OP_BOUNCE: state_nxt = (Cmd_Arg == '0) ? ST_DONE : ST_BNC_DN;
        OP_HOLD:   state_nxt = ST_HOLD;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_dn_counter_seq.sv
// Bench for up_dn_counter_seq with a behavioural saturating counter as the feedback plant.
module tb_up_dn_counter_seq;

  localparam int M = 31;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic [1:0] Cmd_Op;
  logic [4:0] Cmd_Arg;
  logic       Abort;
  logic [4:0] cnt;
  logic       Low, High;
  logic [4:0] IN;
  logic       Load, Up, Down, Busy, Done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  always #5 CLK = ~CLK;

  up_dn_counter_seq dut (
    .CLK(CLK), .RST(RST), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Op(Cmd_Op), .Cmd_Arg(Cmd_Arg), .Abort(Abort),
    .Counter(cnt), .Low(Low), .High(High),
    .IN(IN), .Load(Load), .Up(Up), .Down(Down), .Busy(Busy), .Done(Done)
  );

  // saturating counter plant
  always @(posedge CLK or negedge RST) begin
    if (!RST) cnt <= '0;
    else if (Load) cnt <= IN;
    else if (Down) begin if (cnt != 0) cnt <= cnt - 1'b1; end
    else if (Up) begin if (cnt != 5'd31) cnt <= cnt + 1'b1; end
  end
  assign Low  = (cnt == 0);
  assign High = (cnt == 5'd31);

  always @(negedge CLK) begin
    if (RST) begin
      checks++;
      if ((Up && Down) || (Load && (Up || Down))) begin
        errors++;
        $display("FAIL ctrl_exclusive: Load=%0b Up=%0b Down=%0b, required at most one", Load, Up, Down);
      end
      if (Done) done_seen++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one command, returns latency (acceptance edge to Done, Done cycle counted) and control counts.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] arg, output int lat,
                         output int n_ld, output int n_up, output int n_dn, output int in_at_load);
    int budget;
    int n;
    lat = -1; n_ld = 0; n_up = 0; n_dn = 0; in_at_load = -1;
    @(negedge CLK);
    Cmd_Valid = 1'b1; Cmd_Op = op; Cmd_Arg = arg;
    budget = 0;
    while (!Cmd_Ready && budget < 100) begin @(negedge CLK); budget++; end
    if (!Cmd_Ready) begin
      chk("accept_timeout", 0, 1);
      Cmd_Valid = 1'b0;
      return;
    end
    @(posedge CLK); #1 Cmd_Valid = 1'b0;
    n = 0;
    while (n < 3000) begin
      @(negedge CLK);
      if (Done) begin lat = n + 1; break; end
      if (Load) begin n_ld++; in_at_load = int'(IN); end
      if (Up) n_up++;
      if (Down) n_dn++;
      n++;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  // Reference: what a command must do, from the counter value c at acceptance.
  function automatic void ref_cmd(input int op, input int arg, input int c, output int lat,
                                  output int nc, output int ld, output int up, output int dn);
    ld = 0; up = 0; dn = 0; nc = c; lat = 0;
    case (op)
      0: begin lat = 2; nc = arg; ld = 1; end
      1: begin
        lat = ((c > arg) ? c - arg : arg - c) + 2;
        nc = arg;
        up = (arg > c) ? arg - c : 0;
        dn = (c > arg) ? c - arg : 0;
      end
      2: begin
        if (arg == 0) lat = 1;
        else begin
          lat = c + arg * M + (arg - 1) * M + 2 * arg + 1;
          nc = M;
          dn = c + (arg - 1) * M;
          up = arg * M;
        end
      end
      default: lat = ((arg == 0) ? 1 : arg) + 1;
    endcase
  endfunction

  typedef struct {
    logic [1:0] op;
    logic [4:0] arg;
    int lat;
    int cnt;
    int ld;
    int up;
    int dn;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, ld, up, dn, inl, d0, n;
    int mc, elat, enc, eld, eup, edn;
    logic [1:0] rop;
    logic [4:0] rarg;

    tbl[0]  = '{2'b00, 5'd15, 2,   15, 1, 0,  0};
    tbl[1]  = '{2'b01, 5'd3,  14,  3,  0, 0,  12};
    tbl[2]  = '{2'b01, 5'd3,  2,   3,  0, 0,  0};
    tbl[3]  = '{2'b10, 5'd2,  101, 31, 0, 62, 34};
    tbl[4]  = '{2'b11, 5'd5,  6,   31, 0, 0,  0};
    tbl[5]  = '{2'b11, 5'd0,  2,   31, 0, 0,  0};
    tbl[6]  = '{2'b01, 5'd0,  33,  0,  0, 0,  31};
    tbl[7]  = '{2'b10, 5'd0,  1,   0,  0, 0,  0};
    tbl[8]  = '{2'b10, 5'd1,  34,  31, 0, 31, 0};
    tbl[9]  = '{2'b00, 5'd20, 2,   20, 1, 0,  0};
    tbl[10] = '{2'b01, 5'd31, 13,  31, 0, 11, 0};

    RST = 1'b0; Cmd_Valid = 1'b0; Cmd_Op = 2'b00; Cmd_Arg = '0; Abort = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_cmd_ready", int'(Cmd_Ready), 1);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_ctrls", int'({Load, Up, Down}), 0);
    chk("rst_in", int'(IN), 0);
    RST = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_cmd(tbl[i].op, tbl[i].arg, lat, ld, up, dn, inl);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_counter", i), int'(cnt), tbl[i].cnt);
      chk($sformatf("tbl%0d_loads", i), ld, tbl[i].ld);
      chk($sformatf("tbl%0d_ups", i), up, tbl[i].up);
      chk($sformatf("tbl%0d_downs", i), dn, tbl[i].dn);
      if (tbl[i].op == 2'b00) chk($sformatf("tbl%0d_in", i), inl, int'(tbl[i].arg));
    end

    // HOLD 5 with Cmd_Valid held high: next command only taken off DONE
    @(negedge CLK);
    Cmd_Valid = 1'b1; Cmd_Op = 2'b11; Cmd_Arg = 5'd5;
    @(posedge CLK); #1 Cmd_Op = 2'b00; Cmd_Arg = 5'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hold_ready_low", int'(Cmd_Ready), 0);
      chk("hold_ctrls", int'({Load, Up, Down}), 0);
      chk("hold_done_low", int'(Done), 0);
    end
    @(negedge CLK);
    chk("hold_done", int'(Done), 1);
    chk("hold_done_ready", int'(Cmd_Ready), 1);
    @(posedge CLK); #1 Cmd_Valid = 1'b0;
    @(negedge CLK);
    chk("b2b_load", int'(Load), 1);
    chk("b2b_in", int'(IN), 9);
    @(negedge CLK);
    chk("b2b_done", int'(Done), 1);
    chk("b2b_counter", int'(cnt), 9);

    // Abort in the middle of SEEK 31 from 0
    run_cmd(2'b00, 5'd0, lat, ld, up, dn, inl);
    chk("abort_pre_counter", int'(cnt), 0);
    @(negedge CLK);
    Cmd_Valid = 1'b1; Cmd_Op = 2'b01; Cmd_Arg = 5'd31;
    @(posedge CLK); #1 Cmd_Valid = 1'b0;
    d0 = done_seen;
    n = 0;
    @(negedge CLK);
    while (cnt != 5'd10 && n < 100) begin @(negedge CLK); n++; end
    chk("abort_reach", int'(cnt), 10);
    chk("abort_up_before", int'(Up), 1);
    Abort = 1'b1;
    #1;
    chk("abort_up_drop", int'(Up), 0);
    @(posedge CLK); #1 Abort = 1'b0;
    @(negedge CLK);
    chk("abort_idle_busy", int'(Busy), 0);
    chk("abort_idle_ready", int'(Cmd_Ready), 1);
    repeat (3) @(negedge CLK);
    chk("abort_counter_held", int'(cnt), 10);
    chk("abort_no_done", done_seen - d0, 0);

    // Asynchronous reset during BOUNCE
    run_cmd(2'b00, 5'd12, lat, ld, up, dn, inl);
    @(negedge CLK);
    Cmd_Valid = 1'b1; Cmd_Op = 2'b10; Cmd_Arg = 5'd2;
    @(posedge CLK); #1 Cmd_Valid = 1'b0;
    repeat (20) @(negedge CLK);
    chk("rst_mid_busy_before", int'(Busy), 1);
    #3 RST = 1'b0;
    #1;
    chk("arst_ctrls", int'({Load, Up, Down}), 0);
    chk("arst_busy", int'(Busy), 0);
    chk("arst_done", int'(Done), 0);
    chk("arst_ready", int'(Cmd_Ready), 1);
    chk("arst_in", int'(IN), 0);
    @(negedge CLK);
    RST = 1'b1;
    run_cmd(2'b00, 5'd7, lat, ld, up, dn, inl);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_counter", int'(cnt), 7);
    chk("post_rst_in", int'(IN), 7);

    // Randomized commands against the reference
    mc = int'(cnt);
    for (int i = 0; i < 40; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rarg = (rop == 2'b10) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ref_cmd(int'(rop), int'(rarg), mc, elat, enc, eld, eup, edn);
      run_cmd(rop, rarg, lat, ld, up, dn, inl);
      chk($sformatf("rnd%0d_op%0d_arg%0d_latency", i, rop, rarg), lat, elat);
      chk($sformatf("rnd%0d_counter", i), int'(cnt), enc);
      chk($sformatf("rnd%0d_ctrl_counts", i), ld * 10000 + up * 100 + dn, eld * 10000 + eup * 100 + edn);
      mc = enc;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
